// File: rtl/strength_bus_pkg.sv
// Shared encodings for the strength-resolved bus keeper: drive strengths,
// tie-resolution modes and keeper states.
package strength_bus_pkg;

  localparam logic [1:0] STR_NONE   = 2'd0;
  localparam logic [1:0] STR_PULL   = 2'd1;
  localparam logic [1:0] STR_STRONG = 2'd2;
  localparam logic [1:0] STR_SUPPLY = 2'd3;

  localparam logic [1:0] MODE_WAND   = 2'd0;
  localparam logic [1:0] MODE_WOR    = 2'd1;
  localparam logic [1:0] MODE_STRICT = 2'd2;

  typedef enum logic [1:0] {
    ST_DECAYED = 2'd0,
    ST_DRIVEN  = 2'd1,
    ST_HELD    = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_resolve_core.sv
// Combinational resolver: finds the strongest active drivers and merges
// their data according to the tie mode, flagging disagreement among them.
module bus_resolve_core
  import strength_bus_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic [N_CH-1:0]   drv_en,
  input  logic [N_CH*W-1:0] drv_data,
  input  logic [N_CH*2-1:0] drv_str,
  input  logic [1:0]        mode,
  output logic [W-1:0]      o_resolved,
  output logic              o_any_active,
  output logic              o_contention
);

  logic [1:0]   w_smax;
  logic [W-1:0] w_and;
  logic [W-1:0] w_or;
  logic [W-1:0] w_first;
  logic         w_have_first;
  logic         w_differ;

  always_comb begin
    w_smax = STR_NONE;
    for (int c = 0; c < N_CH; c++) begin
      if (drv_en[c] && (drv_str[c*2 +: 2] > w_smax)) w_smax = drv_str[c*2 +: 2];
    end
  end

  // The first winner is the reference; any other winner that disagrees is contention.
  always_comb begin
    w_and        = '1;
    w_or         = '0;
    w_first      = '0;
    w_have_first = 1'b0;
    w_differ     = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (drv_en[c] && (w_smax != STR_NONE) && (drv_str[c*2 +: 2] == w_smax)) begin
        w_and = w_and & drv_data[c*W +: W];
        w_or  = w_or | drv_data[c*W +: W];
        if (!w_have_first) begin
          w_first      = drv_data[c*W +: W];
          w_have_first = 1'b1;
        end else if (drv_data[c*W +: W] != w_first) begin
          w_differ = 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (mode)
      MODE_WAND:   o_resolved = w_and;
      MODE_STRICT: o_resolved = w_first;
      default:     o_resolved = w_or;
    endcase
  end

  assign o_any_active = (w_smax != STR_NONE);
  assign o_contention = w_differ;

endmodule

// File: rtl/strength_bus_keeper.sv
// Registered shared-bus resolver with a keeper that holds the last value for
// KEEP_CYCLES after release, then decays to DECAY_VAL.
module strength_bus_keeper
  import strength_bus_pkg::*;
#(
  parameter int             N_CH        = 4,
  parameter int             W           = 8,
  parameter int             KEEP_CYCLES = 16,
  parameter int             CNT_W       = 8,
  parameter logic [W-1:0]   DECAY_VAL   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   drv_en,
  input  logic [N_CH*W-1:0] drv_data,
  input  logic [N_CH*2-1:0] drv_str,
  input  logic [1:0]        mode,
  input  logic              clr_cnt,
  output logic [W-1:0]      bus_out,
  output logic              bus_valid,
  output logic [1:0]        bus_state,
  output logic              contention,
  output logic [CNT_W-1:0]  contention_cnt
);

  localparam int KEEP_W = (KEEP_CYCLES > 0 && $clog2(KEEP_CYCLES + 1) > 1) ?
                          $clog2(KEEP_CYCLES + 1) : 1;
  localparam logic [KEEP_W-1:0] KEEP_LAST = KEEP_W'(KEEP_CYCLES - 1);

  logic [W-1:0]      w_resolved;
  logic              w_any_active;
  logic              w_contention;

  bus_state_e        r_state, w_state_nxt;
  logic [W-1:0]      r_bus, w_bus_nxt;
  logic [KEEP_W-1:0] r_keep_cnt, w_keep_nxt;
  logic              r_contention;
  logic [CNT_W-1:0]  r_cnt;

  bus_resolve_core #(.N_CH(N_CH), .W(W)) u_core (
    .drv_en       (drv_en),
    .drv_data     (drv_data),
    .drv_str      (drv_str),
    .mode         (mode),
    .o_resolved   (w_resolved),
    .o_any_active (w_any_active),
    .o_contention (w_contention)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_bus_nxt   = r_bus;
    w_keep_nxt  = r_keep_cnt;
    if (w_any_active) begin
      w_state_nxt = ST_DRIVEN;
      w_keep_nxt  = '0;
      // Strict mode refuses to pick a winner when drivers disagree.
      if (!((mode == MODE_STRICT) && w_contention)) w_bus_nxt = w_resolved;
    end else begin
      case (r_state)
        ST_DRIVEN: begin
          w_keep_nxt = '0;
          if (KEEP_CYCLES > 0) begin
            w_state_nxt = ST_HELD;
          end else begin
            w_state_nxt = ST_DECAYED;
            w_bus_nxt   = DECAY_VAL;
          end
        end
        ST_HELD: begin
          if (r_keep_cnt == KEEP_LAST) begin
            w_state_nxt = ST_DECAYED;
            w_bus_nxt   = DECAY_VAL;
            w_keep_nxt  = '0;
          end else begin
            w_keep_nxt = r_keep_cnt + KEEP_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_DECAYED;
          w_bus_nxt   = DECAY_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_DECAYED;
      r_bus        <= DECAY_VAL;
      r_keep_cnt   <= '0;
      r_contention <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_bus        <= w_bus_nxt;
      r_keep_cnt   <= w_keep_nxt;
      r_contention <= w_contention;
      if (clr_cnt)                                r_cnt <= '0;
      else if (w_contention && (r_cnt != '1))     r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus_out        = r_bus;
  assign bus_valid      = (r_state != ST_DECAYED);
  assign bus_state      = r_state;
  assign contention     = r_contention;
  assign contention_cnt = r_cnt;

endmodule

// File: tb/tb_strength_bus_keeper.sv
// Self-checking bench for strength_bus_keeper: directed scenarios plus
// randomized traffic against a queue-based behavioural model.
module tb_strength_bus_keeper;

  localparam int N_CH = 4;
  localparam int W = 8;
  localparam int KEEP = 16;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [W-1:0] DV = 8'h00;

  logic clk = 1'b0;
  logic rst_n;
  logic [N_CH-1:0] drv_en;
  logic [N_CH*W-1:0] drv_data;
  logic [N_CH*2-1:0] drv_str;
  logic [1:0] mode;
  logic clr_cnt;
  logic [W-1:0] bus_out;
  logic bus_valid;
  logic [1:0] bus_state;
  logic contention;
  logic [CNT_W-1:0] contention_cnt;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [W-1:0] m_bus;
  int m_state;
  int m_left;
  int m_cnt;
  logic m_cont;

  strength_bus_keeper #(
    .N_CH(N_CH), .W(W), .KEEP_CYCLES(KEEP), .CNT_W(CNT_W), .DECAY_VAL(DV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data),
    .drv_str(drv_str), .mode(mode), .clr_cnt(clr_cnt), .bus_out(bus_out),
    .bus_valid(bus_valid), .bus_state(bus_state), .contention(contention),
    .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_bus = DV; m_state = 0; m_left = 0; m_cnt = 0; m_cont = 1'b0;
  endtask

  // Evaluate the spec rules on the current inputs and advance one edge.
  task automatic model_step();
    int smax = 0;
    logic [W-1:0] win[$];
    logic [W-1:0] a, o;
    logic cont;
    for (int c = 0; c < N_CH; c++)
      if (drv_en[c] && int'(drv_str[c*2 +: 2]) > smax) smax = int'(drv_str[c*2 +: 2]);
    if (smax > 0)
      for (int c = 0; c < N_CH; c++)
        if (drv_en[c] && int'(drv_str[c*2 +: 2]) == smax) win.push_back(drv_data[c*W +: W]);
    a = '1; o = '0; cont = 1'b0;
    foreach (win[i]) begin
      a &= win[i];
      o |= win[i];
      if (win[i] != win[0]) cont = 1'b1;
    end
    m_cont = cont;
    if (clr_cnt) m_cnt = 0;
    else if (cont && m_cnt < CNT_MAX) m_cnt++;
    if (smax > 0) begin
      m_state = 1;
      if (mode == 2'd2) begin
        if (!cont) m_bus = win[0];
      end else if (mode == 2'd0) m_bus = a;
      else m_bus = o;
    end else if (m_state == 1) begin
      if (KEEP > 0) begin m_state = 2; m_left = KEEP - 1; end
      else begin m_state = 0; m_bus = DV; end
    end else if (m_state == 2) begin
      if (m_left == 0) begin m_state = 0; m_bus = DV; end
      else m_left--;
    end else begin
      m_bus = DV;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    drv_en = '0; drv_data = '0; drv_str = '0; clr_cnt = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic [1:0] s, input logic [W-1:0] d);
    drv_en[c] = 1'b1; drv_str[c*2 +: 2] = s; drv_data[c*W +: W] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); mode = 2'd1; model_reset();
    #12;
    total++;
    if ({bus_out, bus_valid, bus_state, contention, contention_cnt} !== {DV, 1'b0, 2'd0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL reset: got bus=%h v=%b st=%0d c=%b n=%0d want bus=%h v=0 st=0 c=0 n=0",
               bus_out, bus_valid, bus_state, contention, contention_cnt, DV);
    end
    @(negedge clk); rst_n = 1'b1;
    drv_en = '1; drv_str = '0; drv_data = 32'hDEADBEEF;
    cycle();
    total++;
    if (bus_state !== 2'd0 || bus_valid !== 1'b0 || bus_out !== DV) begin
      bad++;
      $display("FAIL str0_ignored: got st=%0d v=%b bus=%h want st=0 v=0 bus=%h", bus_state, bus_valid, bus_out, DV);
    end
  endtask

  task automatic test_strength_priority();
    idle_inputs(); mode = 2'd1;
    set_ch(0, 2'd2, 8'h0F); set_ch(1, 2'd1, 8'hF0);
    cycle();
    total++;
    if (bus_out !== 8'h0F || contention !== 1'b0 || bus_state !== 2'd1 || bus_valid !== 1'b1) begin
      bad++;
      $display("FAIL strength_priority: got bus=%h c=%b st=%0d v=%b want bus=0f c=0 st=1 v=1",
               bus_out, contention, bus_state, bus_valid);
    end
  endtask

  task automatic test_wand_wor();
    idle_inputs(); clr_cnt = 1'b1; cycle();
    idle_inputs(); mode = 2'd0;
    set_ch(0, 2'd2, 8'h3C); set_ch(2, 2'd2, 8'h0F);
    cycle();
    total++;
    if (bus_out !== 8'h0C || contention !== 1'b1 || contention_cnt !== 2'd1) begin
      bad++;
      $display("FAIL wand: got bus=%h c=%b n=%0d want bus=0c c=1 n=1", bus_out, contention, contention_cnt);
    end
    mode = 2'd1;
    cycle();
    total++;
    if (bus_out !== 8'h3F || contention !== 1'b1 || contention_cnt !== 2'd2) begin
      bad++;
      $display("FAIL wor: got bus=%h c=%b n=%0d want bus=3f c=1 n=2", bus_out, contention, contention_cnt);
    end
    mode = 2'd3;
    drv_data[2*W +: W] = 8'h81;
    cycle();
    total++;
    if (bus_out !== 8'hBD) begin
      bad++;
      $display("FAIL reserved_as_wor: got bus=%h want bus=bd", bus_out);
    end
  endtask

  task automatic test_strict();
    idle_inputs(); mode = 2'd2;
    set_ch(0, 2'd1, 8'hA5);
    cycle();
    total++;
    if (bus_out !== 8'hA5 || contention !== 1'b0) begin
      bad++;
      $display("FAIL strict_single: got bus=%h c=%b want bus=a5 c=0", bus_out, contention);
    end
    set_ch(1, 2'd3, 8'h11); set_ch(3, 2'd3, 8'h22);
    cycle();
    total++;
    if (bus_out !== 8'hA5 || contention !== 1'b1 || bus_state !== 2'd1) begin
      bad++;
      $display("FAIL strict_contend: got bus=%h c=%b st=%0d want bus=a5 c=1 st=1", bus_out, contention, bus_state);
    end
    drv_en[1] = 1'b0; drv_en[0] = 1'b0;
    cycle();
    total++;
    if (bus_out !== 8'h22 || contention !== 1'b0) begin
      bad++;
      $display("FAIL strict_recover: got bus=%h c=%b want bus=22 c=0", bus_out, contention);
    end
  endtask

  task automatic test_keeper();
    idle_inputs(); mode = 2'd1;
    set_ch(2, 2'd1, 8'h55);
    cycle();
    for (int pass = 0; pass < 2; pass++) begin
      idle_inputs();
      if (pass == 0) begin
        for (int i = 0; i < 10; i++) cycle();
        total++;
        if (bus_state !== 2'd2 || bus_out !== 8'h55) begin
          bad++;
          $display("FAIL held_cycle10: got st=%0d bus=%h want st=2 bus=55", bus_state, bus_out);
        end
        set_ch(1, 2'd2, 8'h66);
        cycle();
        total++;
        if (bus_state !== 2'd1 || bus_out !== 8'h66) begin
          bad++;
          $display("FAIL redrive: got st=%0d bus=%h want st=1 bus=66", bus_state, bus_out);
        end
      end else begin
        for (int i = 0; i < KEEP; i++) begin
          cycle();
          total++;
          if (bus_state !== 2'd2 || bus_valid !== 1'b1 || bus_out !== 8'h66) begin
            bad++;
            $display("FAIL hold_%0d: got st=%0d v=%b bus=%h want st=2 v=1 bus=66",
                     i, bus_state, bus_valid, bus_out);
          end
        end
        cycle();
        total++;
        if (bus_state !== 2'd0 || bus_valid !== 1'b0 || bus_out !== DV) begin
          bad++;
          $display("FAIL decay: got st=%0d v=%b bus=%h want st=0 v=0 bus=%h", bus_state, bus_valid, bus_out, DV);
        end
      end
    end
  endtask

  task automatic test_saturate();
    idle_inputs(); clr_cnt = 1'b1; cycle();
    idle_inputs(); mode = 2'd0;
    set_ch(0, 2'd3, 8'h01); set_ch(3, 2'd3, 8'h02);
    for (int i = 0; i < 5; i++) cycle();
    total++;
    if (contention_cnt !== 2'd3 || contention !== 1'b1) begin
      bad++;
      $display("FAIL saturate: got n=%0d c=%b want n=3 c=1", contention_cnt, contention);
    end
    clr_cnt = 1'b1;
    cycle();
    total++;
    if (contention_cnt !== 2'd0 || contention !== 1'b1) begin
      bad++;
      $display("FAIL clr_wins: got n=%0d c=%b want n=0 c=1", contention_cnt, contention);
    end
    clr_cnt = 1'b0;
  endtask

  task automatic test_async_reset();
    idle_inputs(); mode = 2'd1;
    set_ch(0, 2'd2, 8'h77);
    cycle();
    idle_inputs();
    for (int i = 0; i < 5; i++) cycle();
    @(posedge clk);
    model_step();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({bus_out, bus_valid, bus_state, contention, contention_cnt} !== {DV, 1'b0, 2'd0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL async_reset: got bus=%h v=%b st=%0d c=%b n=%0d want all reset",
               bus_out, bus_valid, bus_state, contention, contention_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    drv_en = '1; drv_str = '0; drv_data = '1;
    cycle();
    total++;
    if (bus_state !== 2'd0 || bus_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_str0: got st=%0d v=%b want st=0 v=0", bus_state, bus_valid);
    end
  endtask

  task automatic test_random();
    int idle_run = 0;
    for (int n = 0; n < 600; n++) begin
      mode = 2'($urandom_range(0, 3));
      clr_cnt = ($urandom_range(0, 15) == 0);
      if (idle_run == 0 && $urandom_range(0, 9) == 0) idle_run = $urandom_range(1, 22);
      for (int c = 0; c < N_CH; c++) begin
        drv_en[c] = (idle_run == 0) && ($urandom_range(0, 2) != 0);
        drv_str[c*2 +: 2] = 2'($urandom_range(0, 3));
        drv_data[c*W +: W] = ($urandom_range(0, 2) == 0) ? 8'h5A : 8'($urandom);
      end
      if (idle_run > 0) idle_run--;
      cycle();
      total++;
      if ({bus_out, bus_valid, bus_state, contention, contention_cnt} !==
          {m_bus, (m_state != 0), 2'(m_state), m_cont, CNT_W'(m_cnt)}) begin
        bad++;
        $display("FAIL random_%0d: got bus=%h v=%b st=%0d c=%b n=%0d want bus=%h v=%b st=%0d c=%b n=%0d",
                 n, bus_out, bus_valid, bus_state, contention, contention_cnt,
                 m_bus, (m_state != 0), m_state, m_cont, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_strength_priority();
    test_wand_wor();
    test_strict();
    test_keeper();
    test_saturate();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/strength_bus_keeper.md
Name: strength_bus_keeper

Overview:
- N-channel shared-bus resolver: each channel drives a W-bit value with an enable and a 2-bit drive strength.
- Each cycle the strongest enabled drivers win. Ties among winners are resolved by a run-time mode: wired-AND, wired-OR, or strict, where strict flags contention.
- The resolved value is registered. When no channel drives, a keeper holds the last value for a programmable time and then decays to a fixed value, like a charge-storage net.
- Sits between multiple bus masters and a single shared consumer.

Parameters:
- N_CH, 4, number of driver channels (2..16)
- W, 8, bus data width
- KEEP_CYCLES, 16, cycles the keeper holds the last value after all drivers release (0 = decay immediately)
- CNT_W, 8, width of the saturating contention counter
- DECAY_VAL, 0, W-bit value presented after decay and at reset

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- drv_en  in  N_CH  per-channel drive enable
- drv_data  in  N_CH*W  channel c occupies bits [c*W +: W]
- drv_str  in  N_CH*2  channel c occupies bits [c*2 +: 2]; 0=none, 1=pull, 2=strong, 3=supply
- mode  in  2  0=wand, 1=wor, 2=strict, 3=reserved (behaves as wor)
- clr_cnt  in  1  synchronous clear of contention_cnt
- bus_out  out  W  resolved, registered bus value
- bus_valid  out  1  1 when bus_out is driven or kept; 0 when decayed
- bus_state  out  2  0=DECAYED, 1=DRIVEN, 2=HELD
- contention  out  1  one-cycle pulse, registered with bus_out
- contention_cnt  out  CNT_W  saturating count of contention cycles

Behaviour:
- Active channel: drv_en=1 and drv_str!=0. Channels with str=0 are ignored even if enabled.
- smax = maximum strength over active channels. Winning set = active channels with strength smax.
- Contention: the winning set has at least 2 members whose drv_data differ in any bit. It is evaluated in every mode.
- Resolved value:
  - wand: bitwise AND over the winning set.
  - wor / reserved: bitwise OR over the winning set.
  - strict: the common value if there is no contention; on contention bus_out keeps its previous value.
- Latency: 1 cycle. Inputs sampled at edge k appear on bus_out, contention and bus_state after edge k.
- FSM, evaluated at each edge:
  - Any state, some channel active: go to DRIVEN and load the resolved value (strict contention excepted).
  - DRIVEN, no channel active: if KEEP_CYCLES>0, go to HELD with keep_cnt=0, bus_out unchanged. If KEEP_CYCLES=0, go to DECAYED.
  - HELD, no channel active: if keep_cnt==KEEP_CYCLES-1, go to DECAYED and set bus_out=DECAY_VAL; otherwise keep_cnt+1. The held value is visible for exactly KEEP_CYCLES cycles.
  - DECAYED, no channel active: stay, bus_out=DECAY_VAL.
- bus_valid = 1 in DRIVEN and HELD, 0 in DECAYED.
- keep_cnt width: clog2(KEEP_CYCLES+1), minimum 1.
- contention_cnt:
  - Increments on each cycle in which contention is registered; saturates at 2^CNT_W-1.
  - clr_cnt=1 sets it to 0 at the next edge. Clear wins over a same-cycle increment.
- Reset (asynchronous, mid-operation included) sets:
  - bus_out=DECAY_VAL, bus_valid=0, bus_state=DECAYED
  - keep_cnt=0, contention=0, contention_cnt=0
- Release after reset is synchronous to clk.
- mode may change on any cycle and takes effect for inputs sampled on that cycle.

Decomposition:
- Package strength_bus_pkg: strength encoding constants (STR_NONE/PULL/STRONG/SUPPLY), mode encoding constants (MODE_WAND/WOR/STRICT), and state encoding constants (ST_DECAYED/DRIVEN/HELD).
- Sub-module bus_resolve_core: purely combinational. It takes drv_en, drv_data, drv_str and mode, and outputs resolved value, any_active and contention.
- The top level holds the FSM, keeper counter, output registers and contention counter.

Test Plan:
- N_CH=4, W=8, wor: ch0 str2 0x0F, ch1 str1 0xF0 -> bus_out=0x0F one cycle later, contention=0 (the weaker driver is ignored).
- wand: ch0 and ch2 both str2, 0x3C and 0x0F -> bus_out=0x0C, contention pulse=1, contention_cnt=1. Same inputs in wor -> bus_out=0x3F, contention_cnt=2.
- strict: bus_out=0xA5 established, then ch1 and ch3 str3 with 0x11 and 0x22 -> bus_out stays 0xA5, contention=1. Next cycle ch3 alone -> bus_out=0x22.
- KEEP_CYCLES=16: drive 0x55, then release all -> HELD with 0x55 and bus_valid=1 for exactly 16 cycles, then DECAYED with bus_out=0x00 and bus_valid=0. Re-drive on held cycle 10 -> back to DRIVEN, and a later release restarts the full 16-cycle hold.
- CNT_W=2: 5 consecutive contention cycles -> contention_cnt=3 (saturated). clr_cnt asserted on a contention cycle -> 0.
- Assert rst_n=0 mid-HELD, between clock edges -> outputs immediately go to DECAY_VAL, valid=0, state=0, cnt=0. All channels enabled with str=0 -> state stays DECAYED.
